jt49_div_bank: RTL and testbench
================================

# jt49_div_bank

Parametrised multi-channel programmable divider; successor to the single-channel tone divider. Each of CH channels has its own period, mode and restart strobe. Modes are square, pulse, one-shot and hold. A registered wrap strobe goes to downstream noise/envelope logic. Sits between the register file and the tone/noise/envelope generators, clocked on the core's divided clock.

## Interface
- W, 12: counter and period width, ≥2
- CH, 3: number of channels, ≥1
- clk  in  1: core clock
- rst_n  in  1: reset, synchronous, active-low
- cen  in  1: clock enable; counting advances only when high
- period  in  CH*W: channel n period at bits [n*W +: W]
- mode  in  2*CH: channel n mode at bits [2n +: 2]
- restart  in  CH: per-channel restart strobe, one clk wide
- div  out  CH: per-channel divider output, registered
- tick  out  CH: per-channel wrap strobe, registered, one clk wide

## Operation
- Per-channel state:
  - count, W bits
  - div bit
  - halted bit, one-shot only
- A channel wraps on a cen edge when it is not halted, its mode is not HOLD, period≠0 and count≥period.
  - On wrap: count←1.
  - Otherwise, when advancing: count←count+1.
  - Using ≥ (not ==) means lowering period mid-count wraps on the next cen edge.
- Modes (2-bit):
  - 0 SQUARE: div toggles on wrap; output period is 2·period cen cycles.
  - 1 PULSE: div←wrap on every cen edge; high for one cen cycle per period.
  - 2 ONESHOT: on the first wrap, div←1 and halted←1. While halted: count frozen, div stays 1, no further tick.
  - 3 HOLD: count and div frozen; tick never asserted.
- period==0, any mode: on each cen edge div←0, count←1, tick never asserted.
- restart[n]:
  - Acts on any clk edge regardless of cen.
  - Sets count←1, div←0, halted←0.
  - Has priority over a same-cycle wrap, and suppresses tick for that cycle.
- halted clears when mode≠ONESHOT is sampled on a cen edge, or on restart.
- Mode change on a cen edge:
  - count is preserved.
  - The new mode governs that same edge's update.
- Channels are fully independent; no shared counters.

## Timing
- Reset (rst_n low at a clk edge):
  - count←1, div←0, halted←0, tick←0 for all channels.
  - Reset overrides restart and cen.
- tick[n] is updated every clk: tick←cen & wrap & ~restart.
  - High for exactly one clk after the wrapping edge, even when cen stays high.
- div changes only on clk edges:
  - edges with cen high (count/mode logic), or
  - restart/reset edges.
- Latency: with count=k<period, the wrap occurs (period−k+1) cen edges later. From reset or restart, the first wrap occurs on the period-th cen edge.
- cen low: all state holds except restart/reset effects; tick←0.

## Structure
- Shared package (per codebase header/package convention) holds the mode encodings: SQUARE=2'd0, PULSE=2'd1, ONESHOT=2'd2, HOLD=2'd3.
- Sub-module jt49_div_ch:
  - One channel, parameter W.
  - Ports: clk, rst_n, cen, period, mode, restart, div, tick.
- Top jt49_div_bank:
  - Generate loop over CH.
  - Slices the packed buses.
  - No logic of its own.

## Test plan
- Reset/square: W=12, CH=3, cen=1 every clk, period[0]=3, mode SQUARE.
  - div[0] toggles on cen edges 3, 6, 9 after reset (6-cycle square).
  - tick[0] is one clk wide at those edges.
  - All outputs 0 during reset.
- Pulse plus cen gating: period=4, PULSE, cen high every other clk.
  - div high for one cen period every 4 cen edges (8 clk).
  - tick one clk wide, never two consecutive.
- One-shot and restart: period=5, ONESHOT.
  - div rises on cen edge 5 and stays 1 with no further tick for 20 edges.
  - restart pulse → div=0, count=1 next clk.
  - Next rise 5 cen edges after restart.
- Simultaneous restart and wrap: restart asserted on the edge where count=period.
  - No tick, div=0, count=1.
  - Next wrap period edges later.
- Period changes: mid-count, lower period from 10 to 2 while count=6.
  - Wrap on the next cen edge.
  - Then set period=0 → div forced 0 and tick silent for 10 edges.
- HOLD and independence: channel 1 in HOLD with div=1 while channel 0/2 run SQUARE with periods 2/7.
  - Channel 1 frozen.
  - Channels 0/2 toggle every 2/7 cen edges unaffected.

Source files
------------

// File: rtl/jt49_div_bank_pkg.sv
// ----------------------------------------------------------------------------
// jt49_div_bank_pkg
// Shared definitions for the multi-channel programmable divider bank.
//   - div_mode_e : 2-bit per-channel divider mode encoding
//   - is_frozen  : tells whether a channel's counter must hold this cen edge
// ----------------------------------------------------------------------------
package jt49_div_bank_pkg;

    // Per-channel divider modes, as written by the register file.
    typedef enum logic [1:0] {
        MODE_SQUARE  = 2'd0,  // div toggles on every wrap
        MODE_PULSE   = 2'd1,  // div high for the cen cycle following a wrap
        MODE_ONESHOT = 2'd2,  // first wrap sets div and halts the channel
        MODE_HOLD    = 2'd3   // counter and div frozen
    } div_mode_e;

    // A channel holds its count and div when parked in HOLD, or when it is a
    // one-shot that has already fired.
    function automatic logic is_frozen(input div_mode_e mode_v, input logic halted_v);
        logic frozen_v;
        if (mode_v == MODE_HOLD) begin
            frozen_v = 1'b1;
        end else if (mode_v == MODE_ONESHOT) begin
            frozen_v = halted_v;
        end else begin
            frozen_v = 1'b0;
        end
        return frozen_v;
    endfunction

endpackage

// File: rtl/jt49_div_ch.sv
// ----------------------------------------------------------------------------
// jt49_div_ch
// One channel of the programmable divider bank.
// Ports:
//   clk      in   core clock
//   rst_n    in   synchronous active-low reset
//   cen      in   clock enable; the counter advances only when high
//   period   in   W-bit divide period (0 parks the channel with div low)
//   mode     in   2-bit mode, see div_mode_e
//   restart  in   one-clk strobe: count<-1, div<-0, halted<-0 (ignores cen)
//   div      out  registered divider output
//   tick     out  registered one-clk wrap strobe for noise/envelope logic
// ----------------------------------------------------------------------------
module jt49_div_ch
    import jt49_div_bank_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic [W-1:0] period,
    input  logic [1:0]   mode,
    input  logic         restart,
    output logic         div,
    output logic         tick
);

    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    logic [W-1:0] r_count;
    logic         r_div;
    logic         r_halted;
    logic         r_tick;

    div_mode_e    w_mode;
    logic         w_halted_eff;
    logic         w_wrap;
    logic [W-1:0] w_count_nxt;
    logic         w_div_nxt;
    logic         w_halted_nxt;

    assign w_mode = div_mode_e'(mode);

    // Next state for an edge with cen high. The mode sampled on that edge
    // governs the update, so a stale halted flag only counts in ONESHOT.
    always_comb begin
        w_halted_eff = r_halted & (w_mode == MODE_ONESHOT);
        w_wrap       = 1'b0;
        w_count_nxt  = r_count;
        w_div_nxt    = r_div;
        w_halted_nxt = w_halted_eff;

        if (period == CNT_ZERO) begin
            // Parked channel: output low, counter ready to restart at 1.
            w_count_nxt = CNT_ONE;
            w_div_nxt   = 1'b0;
        end else if (is_frozen(w_mode, w_halted_eff)) begin
            // Hold everything; defaults above already keep the state.
            w_count_nxt = r_count;
        end else begin
            // >= rather than == so that lowering period below the running
            // count wraps immediately instead of running to 2^W.
            w_wrap = (r_count >= period);
            if (w_wrap) begin
                w_count_nxt = CNT_ONE;
            end else begin
                w_count_nxt = r_count + CNT_ONE;
            end

            case (w_mode)
                MODE_SQUARE: begin
                    if (w_wrap) begin
                        w_div_nxt = ~r_div;
                    end else begin
                        w_div_nxt = r_div;
                    end
                end
                MODE_PULSE: begin
                    w_div_nxt = w_wrap;
                end
                MODE_ONESHOT: begin
                    if (w_wrap) begin
                        w_div_nxt    = 1'b1;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_div_nxt    = r_div;
                    end
                end
                default: begin
                    w_div_nxt = r_div;
                end
            endcase
        end
    end

    // Channel state register: reset beats restart, restart beats cen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= CNT_ONE;
            r_div    <= 1'b0;
            r_halted <= 1'b0;
            r_tick   <= 1'b0;
        end else if (restart) begin
            r_count  <= CNT_ONE;
            r_div    <= 1'b0;
            r_halted <= 1'b0;
            r_tick   <= 1'b0;
        end else if (cen) begin
            r_count  <= w_count_nxt;
            r_div    <= w_div_nxt;
            r_halted <= w_halted_nxt;
            r_tick   <= w_wrap;
        end else begin
            r_count  <= r_count;
            r_div    <= r_div;
            r_halted <= r_halted;
            r_tick   <= 1'b0;
        end
    end

    assign div  = r_div;
    assign tick = r_tick;

endmodule

// File: rtl/jt49_div_bank.sv
// ----------------------------------------------------------------------------
// jt49_div_bank
// CH independent programmable dividers sharing clk/rst_n/cen.
// Ports:
//   clk      in   core clock
//   rst_n    in   synchronous active-low reset
//   cen      in   clock enable
//   period   in   CH*W: channel n period at [n*W +: W]
//   mode     in   2*CH: channel n mode at [2n +: 2]
//   restart  in   CH: per-channel restart strobes
//   div      out  CH: per-channel divider outputs (registered)
//   tick     out  CH: per-channel wrap strobes (registered, one clk)
// ----------------------------------------------------------------------------
module jt49_div_bank
    import jt49_div_bank_pkg::*;
#(
    parameter int W  = 12,
    parameter int CH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [CH*W-1:0] period,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   restart,
    output logic [CH-1:0]   div,
    output logic [CH-1:0]   tick
);

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        jt49_div_ch #(
            .W(W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .cen     (cen),
            .period  (period[gi*W +: W]),
            .mode    (mode[2*gi +: 2]),
            .restart (restart[gi]),
            .div     (div[gi]),
            .tick    (tick[gi])
        );
    end

endmodule

// File: tb/tb_jt49_div_bank.sv
module tb_jt49_div_bank;

    localparam int W  = 12;
    localparam int CH = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cen = 1'b0;
    logic [CH*W-1:0] period = '0;
    logic [2*CH-1:0] mode = '0;
    logic [CH-1:0]   restart = '0;
    logic [CH-1:0]   div;
    logic [CH-1:0]   tick;

    always #5 clk = ~clk;

    jt49_div_bank #(.W(W), .CH(CH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .period  (period),
        .mode    (mode),
        .restart (restart),
        .div     (div),
        .tick    (tick)
    );

    typedef struct packed {
        logic [CH-1:0] div;
        logic [CH-1:0] tick;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: position inside the period, output level, one-shot latch.
    int   m_pos[CH];
    bit   m_out[CH];
    bit   m_fired[CH];

    task automatic set_ch(input int n, input int p, input int md);
        period[n*W +: W] = p[W-1:0];
        mode[2*n +: 2]   = md[1:0];
    endtask

    // Advance the model by one clk using the inputs currently driven, queue
    // the expected outputs, then let the DUT take the same edge.
    task automatic cycle();
        exp_t e;
        e = '0;
        for (int n = 0; n < CH; n++) begin
            int p;
            int md;
            bit fire;
            p    = int'(period[n*W +: W]);
            md   = int'(mode[2*n +: 2]);
            fire = 1'b0;
            if (!rst_n || restart[n]) begin
                m_pos[n] = 1; m_out[n] = 1'b0; m_fired[n] = 1'b0;
            end else if (cen) begin
                if (md != 2) m_fired[n] = 1'b0;
                if (p == 0) begin
                    m_pos[n] = 1; m_out[n] = 1'b0;
                end else if (md == 3 || (md == 2 && m_fired[n])) begin
                    fire = 1'b0;
                end else begin
                    fire = (m_pos[n] >= p);
                    m_pos[n] = fire ? 1 : m_pos[n] + 1;
                    case (md)
                        0: if (fire) m_out[n] = !m_out[n];
                        1: m_out[n] = fire;
                        2: if (fire) begin m_out[n] = 1'b1; m_fired[n] = 1'b1; end
                        default: fire = fire;
                    endcase
                end
            end
            e.div[n]  = m_out[n];
            e.tick[n] = fire;
        end
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic pulse_restart(input logic [CH-1:0] r);
        restart = r;
        cycle();
        restart = '0;
    endtask

    // Monitor: every clk the DUT presents div/tick; compare against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (div !== e.div) begin
                    errors++;
                    $display("FAIL div t=%0t actual=%b required=%b", $time, div, e.div);
                end
                checks++;
                if (tick !== e.tick) begin
                    errors++;
                    $display("FAIL tick t=%0t actual=%b required=%b", $time, tick, e.tick);
                end
            end
        end
    end

    initial begin
        for (int n = 0; n < CH; n++) begin
            m_pos[n] = 1; m_out[n] = 1'b0; m_fired[n] = 1'b0;
        end

        // Reset, then channel 0 square with period 3, cen every clk.
        rst_n = 1'b0; cen = 1'b1;
        set_ch(0, 3, 0); set_ch(1, 0, 0); set_ch(2, 0, 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(12);

        // Pulse, period 4, cen every other clk.
        set_ch(0, 4, 1);
        pulse_restart(3'b001);
        for (int i = 0; i < 24; i++) begin
            cen = (i % 2) == 0;
            cycle();
        end
        cen = 1'b1;

        // One-shot period 5, long dwell, restart, re-fire.
        set_ch(0, 5, 2);
        pulse_restart(3'b001);
        cycles(25);
        pulse_restart(3'b001);
        cycles(8);

        // Restart on the edge where count reaches period.
        set_ch(0, 3, 0);
        pulse_restart(3'b001);
        cycles(2);
        pulse_restart(3'b001);
        cycles(7);

        // Lower period mid-count, then park with period 0.
        set_ch(0, 10, 0);
        pulse_restart(3'b001);
        cycles(5);
        set_ch(0, 2, 0);
        cycles(3);
        set_ch(0, 0, 0);
        cycles(10);

        // Channel 1 held high while 0 and 2 run square with periods 2 and 7.
        set_ch(1, 1, 0);
        pulse_restart(3'b111);
        cycle();
        set_ch(0, 2, 0); set_ch(1, 1, 3); set_ch(2, 7, 0);
        cycles(30);

        // Randomized traffic, including occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cen   = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            for (int n = 0; n < CH; n++) begin
                restart[n] = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 19) == 0)
                    period[n*W +: W] = W'($urandom_range(0, 9));
                if ($urandom_range(0, 29) == 0)
                    mode[2*n +: 2] = 2'($urandom_range(0, 3));
            end
            cycle();
        end
        restart = '0;
        rst_n   = 1'b1;

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
